player_time_loader: RTL and testbench
=====================================

Name: player_time_loader

Overview:
- Receiving end of the chess-clock time-set path.
- Accepts a one-cycle LOAD strobe carrying a BCD MM:SS preset and validates it.
- Holds the preset and counts it down on the 1 Hz TICK enable while the player's RUN is high.
- Flags time expiry. One instance per player, placed between the setter and the display/control logic.

Parameters:
- INC_SECONDS, 5, increment in seconds (0..59) added on move completion; used only with the optional feature.

Ports:
- CLK  in  1  system clock
- CLR  in  1  asynchronous active-high reset
- CE  in  1  clock enable; gates every state and digit update
- LOAD  in  1  one-cycle preset strobe from the time setter
- LD_M10  in  4  preset tens of minutes, BCD
- LD_M1  in  4  preset minutes, BCD
- LD_S10  in  4  preset tens of seconds, BCD
- LD_S1  in  4  preset seconds, BCD
- RUN  in  1  high while it is this player's turn
- TICK  in  1  1 Hz enable pulse, one CLK wide
- M10, M1, S10, S1  out  4 each  current remaining time, BCD, registered
- LOAD_ACK  out  1  one-cycle pulse: preset accepted
- LOAD_ERR  out  1  one-cycle pulse: preset rejected
- EXPIRED  out  1  level; high while in FLAGGED

Behaviour:
- Reset is CLR, asynchronous, active-high; clock is CLK, rising edge.
- On reset: all digits 0, state EMPTY, LOAD_ACK=0, LOAD_ERR=0, EXPIRED=0.
- CLR asserted mid-count aborts the count immediately; no pulse is emitted.
- With CE=0: state and digits hold; LOAD, TICK and RUN are ignored; LOAD_ACK and LOAD_ERR read 0 on the next edge.
- States: EMPTY (no time), READY (time loaded, paused), RUNNING, FLAGGED (time out).
- LOAD validity: every digit ≤ 9 and LD_S10 ≤ 5.
- LOAD (CE=1) in EMPTY, READY or FLAGGED:
  - Valid preset: digits take the preset on the same edge; LOAD_ACK=1 for the following cycle; EXPIRED cleared.
  - Next state is EMPTY if the preset is 00:00, otherwise READY.
  - Invalid preset: digits and state unchanged; LOAD_ERR=1 for one cycle.
- LOAD in RUNNING: rejected with LOAD_ERR; the count continues unaffected.
- READY with RUN=1 goes to RUNNING. No decrement in the transition cycle, even if TICK=1 in that cycle.
- RUNNING with RUN=0 goes to READY; digits hold.
- RUN in EMPTY or FLAGGED is ignored.
- Countdown happens in RUNNING when RUN=1 and TICK=1; one-second decrement per tick:
  - S1 0→9 borrows from S10.
  - S10 0→5 borrows from M1.
  - M1 0→9 borrows from M10.
- Decrement reaching 00:00 moves to FLAGGED on the same edge; EXPIRED=1 with digits 00:00.
- FLAGGED is left only via a valid LOAD or CLR.
- Priority in READY: LOAD over RUN. LOAD plus RUN in the same cycle → load, stay READY; RUN is sampled again the next cycle.
- LOAD_ACK and LOAD_ERR are never high together; each is high for exactly one cycle per LOAD.
- Maximum representable time is 99:59; there is no wrap below 00:00.

Optional Feature:
- Macro: PLAYER_TIME_LOADER_BONUS_EN.
- Defined: the RUNNING→READY transition (RUN falls, move completed) adds INC_SECONDS to the digits on that edge.
  - BCD add with carry S1→S10 (carry past 5)→M1→M10.
  - Saturates at 99:59.
  - No bonus on entering FLAGGED, and none if the count already reached 00:00.
- Undefined: no increment logic; INC_SECONDS has no effect.

Test Plan:
- CLR, then LOAD with 05:00 → LOAD_ACK pulses 1 cycle later; digits 0,5,0,0; EXPIRED=0; state READY.
- Load 10:00, RUN=1, 1 TICK → digits 0,9,5,9; RUN=0 then 3 TICKs → digits unchanged at 09:59.
- LOAD with 07:65 (S10=6), then a LOAD with M1=4'hA → LOAD_ERR pulses for each; digits keep their prior value.
- Load 00:02, RUN=1, 2 TICKs → 00:01, then 00:00 with EXPIRED=1. Further TICKs hold 00:00. LOAD 01:00 → EXPIRED=0, READY.
- RUNNING at 03:00, pulse LOAD with 09:00 → LOAD_ERR=1, count continues. Assert CLR mid-count → all outputs 0 immediately.
- Macro defined, INC_SECONDS=5: RUNNING at 00:58, RUN falls → 01:03.
  - At 99:57, RUN falls → 99:59 (saturated).
  - Macro undefined: 00:58 stays 00:58.

Source files
------------

// File: rtl/player_time_loader.sv
// Per-player chess-clock time register: validates BCD MM:SS presets, counts down on TICK, flags expiry.
// Optional move bonus enabled by defining PLAYER_TIME_LOADER_BONUS_EN (adds INC_SECONDS when RUN falls).
module player_time_loader #(
  parameter int unsigned INC_SECONDS = 5
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       CE,
  input  logic       LOAD,
  input  logic [3:0] LD_M10,
  input  logic [3:0] LD_M1,
  input  logic [3:0] LD_S10,
  input  logic [3:0] LD_S1,
  input  logic       RUN,
  input  logic       TICK,
  output logic [3:0] M10,
  output logic [3:0] M1,
  output logic [3:0] S10,
  output logic [3:0] S1,
  output logic       LOAD_ACK,
  output logic       LOAD_ERR,
  output logic       EXPIRED
);

  if (INC_SECONDS > 59) begin : gIncRange
    $error("INC_SECONDS must be in 0..59");
  end

  typedef enum logic [1:0] {EMPTY, READY, RUNNING, FLAGGED} state_e;

  state_e     state_q, state_d;
  logic [3:0] m10_q, m1_q, s10_q, s1_q;
  logic [3:0] m10_d, m1_d, s10_d, s1_d;
  logic       ack_q, ack_d, err_q, err_d;

  logic loadValid, presetZero, loadAccept;
  assign loadValid  = (LD_M10 <= 4'd9) && (LD_M1 <= 4'd9) && (LD_S10 <= 4'd5) && (LD_S1 <= 4'd9);
  assign presetZero = ({LD_M10, LD_M1, LD_S10, LD_S1} == 16'h0000);
  assign loadAccept = CE && LOAD && loadValid && (state_q != RUNNING);

  // One-second BCD decrement; RUNNING always holds a nonzero time so M10 never underflows.
  logic       borrowS1, borrowS10, borrowM1, decZero;
  logic [3:0] decM10, decM1, decS10, decS1;
  assign borrowS1  = (s1_q == 4'd0);
  assign borrowS10 = borrowS1 && (s10_q == 4'd0);
  assign borrowM1  = borrowS10 && (m1_q == 4'd0);
  assign decS1     = borrowS1 ? 4'd9 : s1_q - 4'd1;
  assign decS10    = borrowS1 ? (borrowS10 ? 4'd5 : s10_q - 4'd1) : s10_q;
  assign decM1     = borrowS10 ? (borrowM1 ? 4'd9 : m1_q - 4'd1) : m1_q;
  assign decM10    = borrowM1 ? m10_q - 4'd1 : m10_q;
  assign decZero   = ({decM10, decM1, decS10, decS1} == 16'h0000);

`ifdef PLAYER_TIME_LOADER_BONUS_EN
  localparam logic [3:0] INC_S1  = 4'(INC_SECONDS % 10);
  localparam logic [3:0] INC_S10 = 4'(INC_SECONDS / 10);

  logic [4:0] addS1, addS10, addM1, addM10;
  logic       carryS1, carryS10, carryM1, saturate;
  logic [3:0] bonM10, bonM1, bonS10, bonS1;
  assign addS1    = {1'b0, s1_q} + {1'b0, INC_S1};
  assign carryS1  = (addS1 > 5'd9);
  assign addS10   = {1'b0, s10_q} + {1'b0, INC_S10} + {4'd0, carryS1};
  assign carryS10 = (addS10 > 5'd5);
  assign addM1    = {1'b0, m1_q} + {4'd0, carryS10};
  assign carryM1  = (addM1 > 5'd9);
  assign addM10   = {1'b0, m10_q} + {4'd0, carryM1};
  assign saturate = (addM10 > 5'd9);
  assign bonS1    = saturate ? 4'd9 : (carryS1  ? 4'(addS1  - 5'd10) : addS1[3:0]);
  assign bonS10   = saturate ? 4'd5 : (carryS10 ? 4'(addS10 - 5'd6)  : addS10[3:0]);
  assign bonM1    = saturate ? 4'd9 : (carryM1  ? 4'(addM1  - 5'd10) : addM1[3:0]);
  assign bonM10   = saturate ? 4'd9 : addM10[3:0];
`endif

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q <= EMPTY;
      m10_q   <= 4'd0;
      m1_q    <= 4'd0;
      s10_q   <= 4'd0;
      s1_q    <= 4'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      m10_q   <= m10_d;
      m1_q    <= m1_d;
      s10_q   <= s10_d;
      s1_q    <= s1_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  // Any LOAD seen in READY blocks the RUN transition for that cycle, valid or not.
  always_comb begin
    state_d = state_q;
    if (loadAccept) begin
      state_d = presetZero ? EMPTY : READY;
    end else if (CE) begin
      case (state_q)
        READY:   if (!LOAD && RUN) state_d = RUNNING;
        RUNNING: begin
          if (!RUN)                  state_d = READY;
          else if (TICK && decZero)  state_d = FLAGGED;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    m10_d = m10_q;
    m1_d  = m1_q;
    s10_d = s10_q;
    s1_d  = s1_q;
    ack_d = loadAccept;
    err_d = CE && LOAD && !loadAccept;
    if (loadAccept) begin
      {m10_d, m1_d, s10_d, s1_d} = {LD_M10, LD_M1, LD_S10, LD_S1};
    end else if (CE && (state_q == RUNNING)) begin
      if (RUN && TICK) begin
        {m10_d, m1_d, s10_d, s1_d} = {decM10, decM1, decS10, decS1};
      end
`ifdef PLAYER_TIME_LOADER_BONUS_EN
      else if (!RUN) begin
        {m10_d, m1_d, s10_d, s1_d} = {bonM10, bonM1, bonS10, bonS1};
      end
`endif
    end
  end

  always_comb begin
    M10      = m10_q;
    M1       = m1_q;
    S10      = s10_q;
    S1       = s1_q;
    LOAD_ACK = ack_q;
    LOAD_ERR = err_q;
    EXPIRED  = (state_q == FLAGGED);
  end

endmodule

// File: tb/tb_player_time_loader.sv
// Bench for player_time_loader: directed vector table, corner sequences, then random traffic vs a seconds-based model.
module tb_player_time_loader;

  localparam int INC = 5;

  logic       CLK = 1'b0;
  logic       CLR, CE, LOAD, RUN, TICK;
  logic [3:0] LD_M10, LD_M1, LD_S10, LD_S1;
  logic [3:0] M10, M1, S10, S1;
  logic       LOAD_ACK, LOAD_ERR, EXPIRED;

  int compared   = 0;
  int mismatched = 0;

  player_time_loader #(.INC_SECONDS(INC)) dut (
    .CLK(CLK), .CLR(CLR), .CE(CE), .LOAD(LOAD),
    .LD_M10(LD_M10), .LD_M1(LD_M1), .LD_S10(LD_S10), .LD_S1(LD_S1),
    .RUN(RUN), .TICK(TICK),
    .M10(M10), .M1(M1), .S10(S10), .S1(S1),
    .LOAD_ACK(LOAD_ACK), .LOAD_ERR(LOAD_ERR), .EXPIRED(EXPIRED)
  );

  always #5 CLK = ~CLK;

  // Reference model: remaining time held as plain seconds, phase as a small integer.
  localparam int P_EMPTY = 0, P_READY = 1, P_RUN = 2, P_FLAG = 3;
  int   mT, mSt;
  logic mAck, mErr;

  function automatic int bcdToSec(logic [15:0] b);
    return (int'(b[15:12]) * 10 + int'(b[11:8])) * 60 + int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [15:0] secToBcd(int s);
    int m, sec;
    m = s / 60;
    sec = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(sec / 10), 4'(sec % 10)};
  endfunction

  task automatic modelReset();
    mT = 0; mSt = P_EMPTY; mAck = 1'b0; mErr = 1'b0;
  endtask

  task automatic modelStep();
    logic valid;
    int   prev;
    mAck = 1'b0;
    mErr = 1'b0;
    if (CE) begin
      valid = (LD_M10 <= 9) && (LD_M1 <= 9) && (LD_S10 <= 5) && (LD_S1 <= 9);
      prev = mSt;
      if (LOAD && valid && prev != P_RUN) begin
        mT = bcdToSec({LD_M10, LD_M1, LD_S10, LD_S1});
        mSt = (mT == 0) ? P_EMPTY : P_READY;
        mAck = 1'b1;
      end else begin
        if (LOAD) mErr = 1'b1;
        if (prev == P_RUN) begin
          if (!RUN) begin
            mSt = P_READY;
`ifdef PLAYER_TIME_LOADER_BONUS_EN
            if (mT > 0) mT = (mT + INC > 5999) ? 5999 : mT + INC;
`endif
          end else if (TICK) begin
            mT = mT - 1;
            if (mT == 0) mSt = P_FLAG;
          end
        end else if (prev == P_READY && RUN && !LOAD) begin
          mSt = P_RUN;
        end
      end
    end
  endtask

  function automatic logic [18:0] modelOut();
    return {secToBcd(mT), mAck, mErr, (mSt == P_FLAG)};
  endfunction

  task automatic checkOutput(input string name, input logic [18:0] expv);
    logic [18:0] act;
    act = {M10, M1, S10, S1, LOAD_ACK, LOAD_ERR, EXPIRED};
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("[TB] FAIL %s: got time=%h ack/err/exp=%b, expected time=%h ack/err/exp=%b",
               name, act[18:3], act[2:0], expv[18:3], expv[2:0]);
    end
  endtask

  task automatic applyStimulus(input logic ce, input logic load, input logic [15:0] ld,
                               input logic run, input logic tick);
    CE = ce; LOAD = load; RUN = run; TICK = tick;
    {LD_M10, LD_M1, LD_S10, LD_S1} = ld;
    @(posedge CLK);
    #1;
    modelStep();
  endtask

  task automatic doReset();
    CLR = 1'b1; CE = 1'b0; LOAD = 1'b0; RUN = 1'b0; TICK = 1'b0;
    {LD_M10, LD_M1, LD_S10, LD_S1} = 16'h0000;
    modelReset();
    #12;
    checkOutput("reset", 19'h0);
    @(negedge CLK);
    CLR = 1'b0;
  endtask

  typedef struct {
    logic        ce, load;
    logic [15:0] ld;
    logic        run, tick;
    logic [15:0] expT;
    logic        ack, err, expd;
  } vec_t;

  function automatic vec_t mk(logic ce, logic load, logic [15:0] ld, logic run, logic tick,
                              logic [15:0] t, logic ack, logic err, logic ex);
    vec_t r;
    r.ce = ce; r.load = load; r.ld = ld; r.run = run; r.tick = tick;
    r.expT = t; r.ack = ack; r.err = err; r.expd = ex;
    return r;
  endfunction

`ifdef PLAYER_TIME_LOADER_BONUS_EN
  localparam logic [15:0] STOP1 = 16'h1004;
  localparam logic [15:0] BON1  = 16'h0103;
  localparam logic [15:0] BON2  = 16'h9959;
`else
  localparam logic [15:0] STOP1 = 16'h0959;
  localparam logic [15:0] BON1  = 16'h0058;
  localparam logic [15:0] BON2  = 16'h9957;
`endif

  vec_t vecs[$];

  initial begin
    vecs.push_back(mk(1, 1, 16'h0500, 0, 0, 16'h0500, 1, 0, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0500, 0, 0, 0));
    vecs.push_back(mk(1, 1, 16'h1000, 0, 0, 16'h1000, 1, 0, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 1, 1, 16'h1000, 0, 0, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 1, 1, 16'h0959, 0, 0, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, STOP1,    0, 0, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 1, STOP1,    0, 0, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 1, STOP1,    0, 0, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 1, STOP1,    0, 0, 0));
    vecs.push_back(mk(1, 1, 16'h0765, 0, 0, STOP1,    0, 1, 0));
    vecs.push_back(mk(1, 1, 16'h0A00, 0, 0, STOP1,    0, 1, 0));
    vecs.push_back(mk(1, 1, 16'h0002, 0, 0, 16'h0002, 1, 0, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 1, 0, 16'h0002, 0, 0, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 1, 1, 16'h0001, 0, 0, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 1, 1, 16'h0000, 0, 0, 1));
    vecs.push_back(mk(1, 0, 16'h0000, 1, 1, 16'h0000, 0, 0, 1));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 1, 16'h0000, 0, 0, 1));
    vecs.push_back(mk(1, 1, 16'h0100, 0, 0, 16'h0100, 1, 0, 0));
    vecs.push_back(mk(0, 1, 16'h0200, 1, 1, 16'h0100, 0, 0, 0));
    vecs.push_back(mk(1, 1, 16'h0000, 0, 0, 16'h0000, 1, 0, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 1, 1, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(1, 1, 16'h0300, 1, 0, 16'h0300, 1, 0, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 1, 0, 16'h0300, 0, 0, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 1, 1, 16'h0259, 0, 0, 0));
    vecs.push_back(mk(1, 1, 16'h0900, 1, 1, 16'h0258, 0, 1, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 1, 1, 16'h0257, 0, 0, 0));

    doReset();
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].ce, vecs[i].load, vecs[i].ld, vecs[i].run, vecs[i].tick);
      checkOutput($sformatf("vec%0d", i), {vecs[i].expT, vecs[i].ack, vecs[i].err, vecs[i].expd});
    end

    // Asynchronous clear while counting must zero everything before the next edge.
    #2;
    CLR = 1'b1;
    #1;
    checkOutput("clr_midcount", 19'h0);
    @(negedge CLK);
    CLR = 1'b0;
    modelReset();

    applyStimulus(1, 1, 16'h0059, 0, 0);
    checkOutput("bonus_load", {16'h0059, 3'b100});
    applyStimulus(1, 0, 16'h0000, 1, 0);
    applyStimulus(1, 0, 16'h0000, 1, 1);
    checkOutput("bonus_tick", {16'h0058, 3'b000});
    applyStimulus(1, 0, 16'h0000, 0, 0);
    checkOutput("bonus_stop", {BON1, 3'b000});
    applyStimulus(1, 1, 16'h9958, 0, 0);
    applyStimulus(1, 0, 16'h0000, 1, 0);
    applyStimulus(1, 0, 16'h0000, 1, 1);
    checkOutput("max_tick", {16'h9957, 3'b000});
    applyStimulus(1, 0, 16'h0000, 0, 0);
    checkOutput("bonus_sat", {BON2, 3'b000});

    doReset();
    for (int n = 0; n < 3000; n++) begin
      logic [15:0] ld;
      int sel;
      sel = int'($urandom_range(0, 7));
      if (sel == 0)
        ld = 16'($urandom());
      else if (sel == 1)
        ld = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
      else
        ld = {4'd0, 4'($urandom_range(0, 1)), 4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
      applyStimulus(($urandom % 8) != 0, ($urandom % 12) == 0, ld, ($urandom % 6) != 0, ($urandom % 2) == 0);
      checkOutput("random", modelOut());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
